seg7_scan_decoder: RTL and testbench
====================================

# seg7_scan_decoder

Receiver for a time-multiplexed two-digit 7-segment display bus: it samples the segment lines while each digit strobe is active and decodes each digit pattern back to BCD. It combines tens and units into a 6-bit binary value (0..63), the inverse of the switch-to-HEX display path. The decoded value is published only after it has been seen identically on several consecutive scans. It sits between the display scan lines (or a bench/loopback tap) and any logic that must read back the displayed number.

## Interface
- STABLE_SCANS, 3: identical consecutive frames required before a value is accepted (1..15).
- SETTLE_CYCLES, 4: cycles a digit strobe must stay unchanged before seg_in is sampled (1..255).
- TIMEOUT_CYCLES, 1024: cycles without a completed frame before lock is dropped.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- seg_in  in  7  active-high segments, bit0=a … bit6=g.
- dig_sel  in  2  one-hot digit strobe: [0]=units, [1]=tens, 00=blanking, 11=illegal.
- value  out  6  accepted binary value.
- tens_bcd  out  4  accepted tens digit.
- units_bcd  out  4  accepted units digit.
- value_valid  out  1  one-cycle pulse when value is newly accepted.
- locked  out  1  high while an accepted value is current.
- err  out  1  one-cycle pulse on a bad pattern, illegal strobe, or out-of-range frame.

## Operation
- Legal patterns (0..9): 0111111, 0000110, 1011011, 1001111, 1100110, 1101101, 1111101, 0000111, 1111111, 1100111. Any other pattern is invalid.
- FSM states: WAIT_DIG, SETTLE, SAMPLE, WAIT_RELEASE.
  - WAIT_DIG: if dig_sel is 01 or 10, latch it and go to SETTLE. If dig_sel is 11, pulse err and stay. 00 holds.
  - SETTLE: a counter increments while dig_sel equals the latched strobe. Any change returns to WAIT_DIG with the counter cleared. When the counter reaches SETTLE_CYCLES, go to SAMPLE.
  - SAMPLE: decode seg_in into the tens or units slot and set that slot's seen flag, then go to WAIT_RELEASE. An invalid pattern pulses err, clears both seen flags, clears the stable count, and goes to WAIT_RELEASE.
  - WAIT_RELEASE: wait until dig_sel differs from the latched strobe, then go to WAIT_DIG.
- Frame complete: both seen flags are set. The cycle after the completing SAMPLE:
  - Compute sum = tens*10 + units at 7-bit width, then clear both seen flags.
  - If sum > 63: pulse err, clear the stable count, discard the frame.
  - Else if sum equals the candidate: stable count increments, saturating at STABLE_SCANS.
  - Else: candidate = sum and stable count = 1.
- Accept: when the stable count reaches STABLE_SCANS, register value, tens_bcd and units_bcd. Pulse value_valid only if locked was 0 or the candidate differs from value. Set locked = 1.
  - Further matching frames hold the outputs and produce no pulse.
- Repeated sampling of the same slot before the frame completes overwrites that slot.
- Timeout: a counter clears on every completed frame.
  - When it reaches TIMEOUT_CYCLES: locked = 0, stable count = 0, seen flags cleared.
  - value, tens_bcd and units_bcd hold their last accepted values.

## Timing
- Reset values: value=0, tens_bcd=0, units_bcd=0, value_valid=0, err=0, locked=0, FSM in WAIT_DIG, all counters and seen flags 0.
- Sampling edge: the SAMPLE cycle, which is SETTLE_CYCLES+1 cycles after the strobe first appears. seg_in must be stable on that edge.
- Latency: value and value_valid change 2 cycles after the SAMPLE edge of the accepting frame (frame evaluation, then output register).
- err pulses 1 cycle after the offending event: the SAMPLE cycle, the 11 strobe, or frame evaluation.
- Simultaneous frame completion and timeout expiry: completion wins and the timeout counter clears.
- rst asserted mid-frame or mid-settle aborts everything. Outputs are at reset values on the next cycle, and a full STABLE_SCANS frames are needed again.

## Test plan
- Reset, then 3 frames of tens=1100110 and units=1011011 (SETTLE=6 cycles per digit): value=42, tens_bcd=4, units_bcd=2, one value_valid pulse, locked=1. A 4th identical frame produces no pulse.
- Strobe held only 3 cycles (below SETTLE_CYCLES) with garbage on seg_in: no sample and no err. Outputs unchanged.
- After locking on 42, units=0000001 in one frame: err pulses once and value stays 42. Two following frames of 43 give no pulse; the third gives value=43 with one pulse.
- tens=6, units=7 (sum 67): err pulses and value is unchanged. dig_sel=11 for 1 cycle: err pulses once.
- Stop scanning for 1024 cycles: locked falls to 0 and value holds 42. Resume with 42 ×3: value_valid pulses and locked=1.
- Assert rst after the tens slot is sampled: all outputs are 0 the next cycle. Two frames of 15 do not lock; the third locks to value=15.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// Receiver for a multiplexed two-digit 7-segment scan bus. Each digit is decoded back
// to BCD, and a binary value 0..63 is published once it repeats on STABLE_SCANS frames.
module seg7_scan_decoder #(
   parameter int unsigned STABLE_SCANS   = 3,
   parameter int unsigned SETTLE_CYCLES  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] seg_in,
   input  logic [1:0] dig_sel,
   output logic [5:0] value,
   output logic [3:0] tens_bcd,
   output logic [3:0] units_bcd,
   output logic       value_valid,
   output logic       locked,
   output logic       err
);

   localparam logic [1:0] WAIT_DIG     = 2'd0;
   localparam logic [1:0] SETTLE       = 2'd1;
   localparam logic [1:0] SAMPLE       = 2'd2;
   localparam logic [1:0] WAIT_RELEASE = 2'd3;

   localparam int unsigned   TO_W        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE_CYCLES);
   localparam logic [3:0]    STABLE_LAST = 4'(STABLE_SCANS);
   localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0] TO_ONE    = TO_W'(1);

   logic [1:0]      state_q, state_d;
   logic [1:0]      strobe_q, strobe_d;
   logic [7:0]      settle_q, settle_d;
   logic [3:0]      tens_q, tens_d;
   logic [3:0]      units_q, units_d;
   logic            seen_t_q, seen_t_d;
   logic            seen_u_q, seen_u_d;
   logic [3:0]      stable_q, stable_d;
   logic [5:0]      cand_q, cand_d;
   logic [3:0]      cand_t_q, cand_t_d;
   logic [3:0]      cand_u_q, cand_u_d;
   logic            accept_q, accept_d;
   logic [TO_W-1:0] to_q, to_d;
   logic [5:0]      value_q, value_d;
   logic [3:0]      tens_out_q, tens_out_d;
   logic [3:0]      units_out_q, units_out_d;
   logic            valid_q, valid_d;
   logic            locked_q, locked_d;
   logic            err_q, err_d;

   logic [4:0]      dec;
   logic [6:0]      sum;
   logic            frame_done;
   logic [TO_W-1:0] to_inc;

   // Returns {valid, digit}; anything outside the ten legal glyphs is invalid.
   function automatic logic [4:0] decode(input logic [6:0] p);
      case (p)
         7'b0111111: decode = {1'b1, 4'd0};
         7'b0000110: decode = {1'b1, 4'd1};
         7'b1011011: decode = {1'b1, 4'd2};
         7'b1001111: decode = {1'b1, 4'd3};
         7'b1100110: decode = {1'b1, 4'd4};
         7'b1101101: decode = {1'b1, 4'd5};
         7'b1111101: decode = {1'b1, 4'd6};
         7'b0000111: decode = {1'b1, 4'd7};
         7'b1111111: decode = {1'b1, 4'd8};
         7'b1100111: decode = {1'b1, 4'd9};
         default:    decode = 5'b0_0000;
      endcase
   endfunction

   always_comb begin
      state_d     = state_q;
      strobe_d    = strobe_q;
      settle_d    = settle_q;
      tens_d      = tens_q;
      units_d     = units_q;
      seen_t_d    = seen_t_q;
      seen_u_d    = seen_u_q;
      stable_d    = stable_q;
      cand_d      = cand_q;
      cand_t_d    = cand_t_q;
      cand_u_d    = cand_u_q;
      accept_d    = 1'b0;
      to_d        = to_q;
      value_d     = value_q;
      tens_out_d  = tens_out_q;
      units_out_d = units_out_q;
      valid_d     = 1'b0;
      locked_d    = locked_q;
      err_d       = 1'b0;

      dec        = decode(seg_in);
      frame_done = seen_t_q & seen_u_q;
      sum        = 7'(tens_q) * 7'd10 + 7'(units_q);
      to_inc     = to_q + TO_ONE;

      case (state_q)
         WAIT_DIG: begin
            if (dig_sel == 2'b01 || dig_sel == 2'b10) begin
               strobe_d = dig_sel;
               settle_d = '0;
               state_d  = SETTLE;
            end else if (dig_sel == 2'b11) begin
               err_d = 1'b1;
            end
         end
         SETTLE: begin
            if (dig_sel != strobe_q) begin
               settle_d = '0;
               state_d  = WAIT_DIG;
            end else begin
               settle_d = settle_q + 8'd1;
               if (settle_q + 8'd1 == SETTLE_LAST) begin
                  state_d = SAMPLE;
               end
            end
         end
         SAMPLE: begin
            settle_d = '0;
            state_d  = WAIT_RELEASE;
            if (dec[4]) begin
               if (strobe_q[1]) begin
                  tens_d   = dec[3:0];
                  seen_t_d = 1'b1;
               end else begin
                  units_d  = dec[3:0];
                  seen_u_d = 1'b1;
               end
            end else begin
               err_d    = 1'b1;
               seen_t_d = 1'b0;
               seen_u_d = 1'b0;
               stable_d = '0;
            end
         end
         WAIT_RELEASE: begin
            if (dig_sel != strobe_q) begin
               state_d = WAIT_DIG;
            end
         end
         default: state_d = WAIT_DIG;
      endcase

      // Frame evaluation always lands in WAIT_RELEASE, so it never races a SAMPLE update.
      if (frame_done) begin
         seen_t_d = 1'b0;
         seen_u_d = 1'b0;
         to_d     = '0;
         if (sum > 7'd63) begin
            err_d    = 1'b1;
            stable_d = '0;
         end else begin
            if (sum[5:0] == cand_q) begin
               if (stable_q != STABLE_LAST) begin
                  stable_d = stable_q + 4'd1;
               end
            end else begin
               cand_d   = sum[5:0];
               cand_t_d = tens_q;
               cand_u_d = units_q;
               stable_d = 4'd1;
            end
            accept_d = (stable_d == STABLE_LAST);
         end
      end else if (to_inc == TO_LAST) begin
         to_d     = '0;
         locked_d = 1'b0;
         stable_d = '0;
         seen_t_d = 1'b0;
         seen_u_d = 1'b0;
      end else begin
         to_d = to_inc;
      end

      if (accept_q) begin
         value_d     = cand_q;
         tens_out_d  = cand_t_q;
         units_out_d = cand_u_q;
         valid_d     = ~locked_q | (cand_q != value_q);
         locked_d    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= WAIT_DIG;
         strobe_q    <= '0;
         settle_q    <= '0;
         tens_q      <= '0;
         units_q     <= '0;
         seen_t_q    <= 1'b0;
         seen_u_q    <= 1'b0;
         stable_q    <= '0;
         cand_q      <= '0;
         cand_t_q    <= '0;
         cand_u_q    <= '0;
         accept_q    <= 1'b0;
         to_q        <= '0;
         value_q     <= '0;
         tens_out_q  <= '0;
         units_out_q <= '0;
         valid_q     <= 1'b0;
         locked_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         strobe_q    <= strobe_d;
         settle_q    <= settle_d;
         tens_q      <= tens_d;
         units_q     <= units_d;
         seen_t_q    <= seen_t_d;
         seen_u_q    <= seen_u_d;
         stable_q    <= stable_d;
         cand_q      <= cand_d;
         cand_t_q    <= cand_t_d;
         cand_u_q    <= cand_u_d;
         accept_q    <= accept_d;
         to_q        <= to_d;
         value_q     <= value_d;
         tens_out_q  <= tens_out_d;
         units_out_q <= units_out_d;
         valid_q     <= valid_d;
         locked_q    <= locked_d;
         err_q       <= err_d;
      end
   end

   assign value       = value_q;
   assign tens_bcd    = tens_out_q;
   assign units_bcd   = units_out_q;
   assign value_valid = valid_q;
   assign locked      = locked_q;
   assign err         = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: a frame-level model queues expected pulses
// and state snapshots with their cycle numbers; a negedge monitor checks them.
module tb_seg7_scan_decoder;

   localparam int unsigned SETTLE  = 4;
   localparam int unsigned STABLE  = 3;
   localparam int unsigned TIMEOUT = 1024;
   localparam int unsigned HOLD    = SETTLE + 2;
   localparam int unsigned BLANK   = 3;

   logic       clk     = 1'b0;
   logic       rst     = 1'b1;
   logic [6:0] seg_in  = '0;
   logic [1:0] dig_sel = '0;
   logic [5:0] value;
   logic [3:0] tens_bcd;
   logic [3:0] units_bcd;
   logic       value_valid;
   logic       locked;
   logic       err;

   int unsigned cyc    = 0;
   int          n_vec  = 0;
   int          n_fail = 0;

   typedef struct { int unsigned cyc; logic [5:0] v; logic [3:0] t; logic [3:0] u; } vv_t;
   typedef struct { int unsigned cyc; logic lk; logic [5:0] v; logic [3:0] t; logic [3:0] u; } st_t;

   vv_t         exp_vv[$];
   st_t         exp_st[$];
   int unsigned exp_err[$];

   int          m_cand       = -1;
   int unsigned m_stable     = 0;
   bit          m_locked     = 1'b0;
   int          m_value      = 0;
   int unsigned m_last_clear = 0;

   seg7_scan_decoder #(
      .STABLE_SCANS  (STABLE),
      .SETTLE_CYCLES (SETTLE),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .seg_in     (seg_in),
      .dig_sel    (dig_sel),
      .value      (value),
      .tens_bcd   (tens_bcd),
      .units_bcd  (units_bcd),
      .value_valid(value_valid),
      .locked     (locked),
      .err        (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b0111111;
         1: return 7'b0000110;
         2: return 7'b1011011;
         3: return 7'b1001111;
         4: return 7'b1100110;
         5: return 7'b1101101;
         6: return 7'b1111101;
         7: return 7'b0000111;
         8: return 7'b1111111;
         9: return 7'b1100111;
         default: return 7'b0000000;
      endcase
   endfunction

   function automatic bit is_legal(input logic [6:0] p);
      for (int d = 0; d < 10; d++) begin
         if (seg_of(d) == p) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic logic [6:0] bad_pat();
      logic [6:0] p;
      p = 7'($urandom);
      while (is_legal(p)) p = 7'($urandom);
      return p;
   endfunction

   // Edge at which a strobe driven from now would be sampled.
   function automatic int unsigned next_sample();
      return cyc + SETTLE + 2;
   endfunction

   task automatic drive(input logic [1:0] d, input logic [6:0] s, input int unsigned n);
      dig_sel = d;
      seg_in  = s;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic digit(input bit is_tens, input logic [6:0] p);
      drive(is_tens ? 2'b10 : 2'b01, p, HOLD);
      drive(2'b00, 7'($urandom), BLANK);
   endtask

   task automatic snap();
      st_t s;
      s.cyc = cyc;
      s.lk  = m_locked;
      s.v   = 6'(m_value);
      s.t   = 4'(m_value / 10);
      s.u   = 4'(m_value % 10);
      exp_st.push_back(s);
   endtask

   // Frame-level reference: e is the cycle on which the completed frame is evaluated.
   task automatic model_frame(input int t, input int u, input int unsigned e);
      int  sum;
      vv_t x;
      sum = t * 10 + u;
      if (e - m_last_clear > TIMEOUT) begin
         m_locked = 1'b0;
         m_stable = 0;
      end
      m_last_clear = e;
      if (sum > 63) begin
         exp_err.push_back(e);
         m_stable = 0;
      end else begin
         if (sum == m_cand) begin
            if (m_stable < STABLE) m_stable++;
         end else begin
            m_cand   = sum;
            m_stable = 1;
         end
         if (m_stable == STABLE) begin
            if (!m_locked || m_value != sum) begin
               x.cyc = e + 1;
               x.v   = 6'(sum);
               x.t   = 4'(sum / 10);
               x.u   = 4'(sum % 10);
               exp_vv.push_back(x);
            end
            m_value  = sum;
            m_locked = 1'b1;
         end
      end
   endtask

   task automatic frame(input int t, input int u, input bit tens_first, input bit dup);
      int first;
      first = tens_first ? t : u;
      if (dup) digit(tens_first, seg_of((first + int'($urandom_range(1, 9))) % 10));
      digit(tens_first, seg_of(first));
      model_frame(t, u, next_sample() + 1);
      digit(!tens_first, seg_of(tens_first ? u : t));
   endtask

   task automatic bad_digit(input bit is_tens, input logic [6:0] p);
      exp_err.push_back(next_sample());
      m_stable = 0;
      digit(is_tens, p);
   endtask

   task automatic illegal_strobe();
      exp_err.push_back(cyc + 1);
      drive(2'b11, 7'($urandom), 1);
      drive(2'b00, '0, BLANK);
   endtask

   task automatic short_strobe();
      drive(($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01, 7'($urandom), $urandom_range(1, SETTLE));
      drive(2'b00, 7'($urandom), BLANK);
   endtask

   task automatic idle(input int unsigned n);
      drive(2'b00, '0, n);
      if (cyc - m_last_clear >= TIMEOUT) begin
         m_locked = 1'b0;
         m_stable = 0;
      end
   endtask

   task automatic do_reset(input int unsigned n);
      rst     = 1'b1;
      dig_sel = '0;
      seg_in  = '0;
      repeat (n) @(posedge clk);
      #1;
      m_cand   = -1;
      m_stable = 0;
      m_locked = 1'b0;
      m_value  = 0;
      snap();
      rst          = 1'b0;
      m_last_clear = cyc;
   endtask

   always @(negedge clk) begin : monitor
      bit          due;
      int unsigned e;
      vv_t         x;
      st_t         s;

      due = (exp_err.size() > 0) && (exp_err[0] <= cyc);
      if (err || due) begin
         n_vec++;
         if (!due) begin
            n_fail++;
            $display("FAIL err_pulse cyc=%0d got=1 want=0 (no error expected)", cyc);
         end else begin
            e = exp_err.pop_front();
            if (!err || e != cyc) begin
               n_fail++;
               $display("FAIL err_pulse cyc=%0d got=%0b want=1 at cyc %0d", cyc, err, e);
            end
         end
      end

      due = (exp_vv.size() > 0) && (exp_vv[0].cyc <= cyc);
      if (value_valid || due) begin
         n_vec++;
         if (!due) begin
            n_fail++;
            $display("FAIL value_valid cyc=%0d got=1 value=%0d want=no pulse", cyc, value);
         end else begin
            x = exp_vv.pop_front();
            if (!value_valid || x.cyc != cyc || value !== x.v || tens_bcd !== x.t || units_bcd !== x.u) begin
               n_fail++;
               $display("FAIL value_valid cyc=%0d got vv=%0b value=%0d tens=%0d units=%0d want pulse at cyc %0d value=%0d tens=%0d units=%0d",
                        cyc, value_valid, value, tens_bcd, units_bcd, x.cyc, x.v, x.t, x.u);
            end
         end
      end

      if (exp_st.size() > 0 && exp_st[0].cyc <= cyc) begin
         s = exp_st.pop_front();
         n_vec++;
         if (s.cyc != cyc || locked !== s.lk || value !== s.v || tens_bcd !== s.t || units_bcd !== s.u) begin
            n_fail++;
            $display("FAIL state cyc=%0d got locked=%0b value=%0d tens=%0d units=%0d want locked=%0b value=%0d tens=%0d units=%0d",
                     cyc, locked, value, tens_bcd, units_bcd, s.lk, s.v, s.t, s.u);
         end
      end
   end

   initial begin : stim
      int t;
      int u;
      int cur_v;

      do_reset(3);

      // Lock on 42, then a fourth identical frame must stay silent.
      repeat (3) frame(4, 2, 1'b1, 1'b0);
      snap();
      frame(4, 2, 1'b1, 1'b0);
      snap();

      short_strobe();
      snap();

      // Invalid units glyph, then 43 needs three fresh frames.
      digit(1'b1, seg_of(4));
      bad_digit(1'b0, 7'b0000001);
      snap();
      for (int i = 0; i < 3; i++) begin
         frame(4, 3, 1'b1, 1'b0);
         snap();
      end

      frame(6, 7, 1'b1, 1'b0);
      illegal_strobe();
      snap();

      repeat (3) frame(4, 2, 1'b0, 1'b0);
      snap();
      idle(1100);
      snap();
      repeat (3) frame(4, 2, 1'b1, 1'b0);
      snap();

      // Reset after only the tens slot was sampled.
      digit(1'b1, seg_of(1));
      do_reset(1);
      repeat (2) frame(1, 5, 1'b1, 1'b0);
      snap();
      frame(1, 5, 1'b1, 1'b0);
      snap();

      cur_v = 42;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 5))
            0: short_strobe();
            1: illegal_strobe();
            2: bad_digit($urandom_range(0, 1) == 1, bad_pat());
            default: ;
         endcase
         if ($urandom_range(0, 7) == 0) begin
            t = int'($urandom_range(6, 9));
            u = int'($urandom_range(0, 9));
            if (t == 6 && u < 4) u = u + 4;
         end else begin
            if ($urandom_range(0, 2) == 0) cur_v = int'($urandom_range(0, 63));
            t = cur_v / 10;
            u = cur_v % 10;
         end
         frame(t, u, $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0);
         snap();
      end

      idle(10);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
